// File: rtl/clock_phase_gen_if.sv
// Control and phase-output bundle of the two-phase clock sequencer.
// master: bring-up controller driving RUN/STEP/timing; slave: the sequencer itself.
interface clock_phase_gen_if #(
    parameter int unsigned PHASE_W = 4,
    parameter int unsigned CNT_W   = 16
);
    logic               RUN;
    logic               STEP;
    logic [PHASE_W-1:0] HIGH_CYC;
    logic [PHASE_W-1:0] GAP_CYC;
    logic               PHI1;
    logic               nPHI1;
    logic               PHI2;
    logic               nPHI2;
    logic               BUSY;
    logic               STEP_DONE;
    logic [CNT_W-1:0]   CYCLE_CNT;

    modport master (
        output RUN, STEP, HIGH_CYC, GAP_CYC,
        input  PHI1, nPHI1, PHI2, nPHI2, BUSY, STEP_DONE, CYCLE_CNT
    );

    modport slave (
        input  RUN, STEP, HIGH_CYC, GAP_CYC,
        output PHI1, nPHI1, PHI2, nPHI2, BUSY, STEP_DONE, CYCLE_CNT
    );
endinterface

// File: rtl/clock_phase_gen.sv
// Two-phase non-overlapping clock sequencer: IDLE -> P1 -> GAP1 -> P2 -> GAP2 -> (P1 | IDLE).
// Phase and gap lengths are latched on every entry to P1; every output is a flop.
module clock_phase_gen #(
    parameter int unsigned PHASE_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    clock_phase_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        GAP1 = 3'd2,
        P2   = 3'd3,
        GAP2 = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] cnt_q, cnt_d;
    logic [PHASE_W-1:0] h_q, h_d;
    logic [PHASE_W-1:0] g_q, g_d;
    logic               step_q, step_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic               step_done_q, step_done_d;
    logic               phi1_q, phi1_d;
    logic               nphi1_q, nphi1_d;
    logic               phi2_q, phi2_d;
    logic               nphi2_q, nphi2_d;
    logic               busy_q, busy_d;

    logic [PHASE_W-1:0] h_in;
    logic [PHASE_W-1:0] g_in;
    logic [PHASE_W-1:0] cur_len;
    logic               phase_last;

    // Zero programmed lengths are clamped to one CLK.
    always_comb begin
        h_in = (bus.HIGH_CYC == '0) ? PHASE_W'(1) : bus.HIGH_CYC;
        g_in = (bus.GAP_CYC  == '0) ? PHASE_W'(1) : bus.GAP_CYC;
    end

    // Detect the final CLK of the current phase or gap using the latched lengths.
    always_comb begin
        cur_len    = ((state_q == P1) || (state_q == P2)) ? h_q : g_q;
        phase_last = (cnt_q == (cur_len - PHASE_W'(1)));
    end

    // Next-state, cycle bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        h_d         = h_q;
        g_d         = g_q;
        step_d      = step_q;
        cycle_cnt_d = cycle_cnt_q;
        step_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // RUN has priority; a STEP seen together with RUN is a normal run cycle.
                if (bus.RUN) begin
                    state_d = P1;
                    step_d  = 1'b0;
                    h_d     = h_in;
                    g_d     = g_in;
                end else if (bus.STEP) begin
                    state_d = P1;
                    step_d  = 1'b1;
                    h_d     = h_in;
                    g_d     = g_in;
                end
            end
            P1: begin
                if (phase_last) begin
                    state_d = GAP1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PHASE_W'(1);
                end
            end
            GAP1: begin
                if (phase_last) begin
                    state_d = P2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PHASE_W'(1);
                end
            end
            P2: begin
                if (phase_last) begin
                    state_d = GAP2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PHASE_W'(1);
                end
            end
            GAP2: begin
                if (phase_last) begin
                    cnt_d       = '0;
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    step_done_d = step_q;
                    step_d      = 1'b0;
                    if (bus.RUN && !step_q) begin
                        state_d = P1;
                        h_d     = h_in;
                        g_d     = g_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + PHASE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                step_d  = 1'b0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same edge as the state.
        phi1_d  = (state_d == P1);
        nphi1_d = (state_d != P1);
        phi2_d  = (state_d == P2);
        nphi2_d = (state_d != P2);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset to the idle values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            h_q         <= PHASE_W'(1);
            g_q         <= PHASE_W'(1);
            step_q      <= 1'b0;
            cycle_cnt_q <= '0;
            step_done_q <= 1'b0;
            phi1_q      <= 1'b0;
            nphi1_q     <= 1'b1;
            phi2_q      <= 1'b0;
            nphi2_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            h_q         <= h_d;
            g_q         <= g_d;
            step_q      <= step_d;
            cycle_cnt_q <= cycle_cnt_d;
            step_done_q <= step_done_d;
            phi1_q      <= phi1_d;
            nphi1_q     <= nphi1_d;
            phi2_q      <= phi2_d;
            nphi2_q     <= nphi2_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.PHI1      = phi1_q;
    assign bus.nPHI1     = nphi1_q;
    assign bus.PHI2      = phi2_q;
    assign bus.nPHI2     = nphi2_q;
    assign bus.BUSY      = busy_q;
    assign bus.STEP_DONE = step_done_q;
    assign bus.CYCLE_CNT = cycle_cnt_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed bench for clock_phase_gen (CNT_W=4 so counter wrap is reachable quickly).
module tb_clock_phase_gen;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    clock_phase_gen_if #(.PHASE_W(4), .CNT_W(4)) bus ();

    clock_phase_gen #(.PHASE_W(4), .CNT_W(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {PHI1,nPHI1,PHI2,nPHI2,BUSY} at position k of a running machine cycle.
    function automatic logic [4:0] phase_exp(int k, int h, int g);
        int m;
        m = k % (2 * h + 2 * g);
        if (m < h)              return 5'b10011;
        else if (m < h + g)     return 5'b01011;
        else if (m < 2 * h + g) return 5'b01101;
        else                    return 5'b01011;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.RUN  = 1'b0;
        bus.STEP = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        rst = 1'b1;
        bus.RUN = 1'b0;
        bus.STEP = 1'b0;
        bus.HIGH_CYC = 4'd2;
        bus.GAP_CYC = 4'd1;
        #2;
        obs = {bus.PHI1, bus.nPHI1, bus.PHI2, bus.nPHI2, bus.BUSY, bus.STEP_DONE, bus.CYCLE_CNT, 1'b0};
        tests_run++;
        if (obs !== 11'b01010_0_0000_0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, 11'b01010_0_0000_0);
        end
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_wait busy=%b exp=0", bus.BUSY);
        end
    endtask

    task automatic test_run_h2g1();
        logic [4:0] obs;
        do_reset();
        bus.HIGH_CYC = 4'd2;
        bus.GAP_CYC = 4'd1;
        bus.RUN = 1'b1;
        tick();
        for (int n = 0; n < 18; n++) begin
            obs = {bus.PHI1, bus.nPHI1, bus.PHI2, bus.nPHI2, bus.BUSY};
            tests_run++;
            if (obs !== phase_exp(n, 2, 1)) begin
                tests_failed++;
                $display("FAIL run_phase n=%0d got=%b exp=%b", n, obs, phase_exp(n, 2, 1));
            end
            tests_run++;
            if ((bus.PHI1 & bus.PHI2) !== 1'b0) begin
                tests_failed++;
                $display("FAIL run_overlap n=%0d phi1=%b phi2=%b", n, bus.PHI1, bus.PHI2);
            end
            tests_run++;
            if (bus.CYCLE_CNT !== 4'(n / 6)) begin
                tests_failed++;
                $display("FAIL run_count n=%0d got=%0d exp=%0d", n, bus.CYCLE_CNT, n / 6);
            end
            tick();
        end
        bus.RUN = 1'b0;
    endtask

    task automatic test_step();
        logic [4:0] obs;
        do_reset();
        bus.HIGH_CYC = 4'd2;
        bus.GAP_CYC = 4'd1;
        bus.STEP = 1'b1;
        tick();
        bus.STEP = 1'b0;
        for (int n = 0; n < 6; n++) begin
            obs = {bus.PHI1, bus.nPHI1, bus.PHI2, bus.nPHI2, bus.BUSY};
            tests_run++;
            if (obs !== phase_exp(n, 2, 1) || bus.STEP_DONE !== 1'b0) begin
                tests_failed++;
                $display("FAIL step_phase n=%0d got=%b done=%b exp=%b done=0", n, obs, bus.STEP_DONE, phase_exp(n, 2, 1));
            end
            // RUN rising during a step cycle must not extend it
            if (n == 3) bus.RUN = 1'b1;
            tick();
        end
        obs = {bus.PHI1, bus.nPHI1, bus.PHI2, bus.nPHI2, bus.BUSY};
        tests_run++;
        if (obs !== 5'b01010 || bus.STEP_DONE !== 1'b1 || bus.CYCLE_CNT !== 4'd1) begin
            tests_failed++;
            $display("FAIL step_end got=%b done=%b cnt=%0d exp=01010 done=1 cnt=1", obs, bus.STEP_DONE, bus.CYCLE_CNT);
        end
        bus.RUN = 1'b0;
        tick();
        tests_run++;
        if (bus.STEP_DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.PHI1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL step_done_pulse done=%b busy=%b phi1=%b exp=0 0 0", bus.STEP_DONE, bus.BUSY, bus.PHI1);
        end
    endtask

    task automatic test_run_drop();
        logic [4:0] obs;
        do_reset();
        bus.HIGH_CYC = 4'd2;
        bus.GAP_CYC = 4'd1;
        bus.RUN = 1'b1;
        tick();
        for (int n = 0; n < 12; n++) begin
            obs = {bus.PHI1, bus.nPHI1, bus.PHI2, bus.nPHI2, bus.BUSY};
            tests_run++;
            if (obs !== phase_exp(n, 2, 1)) begin
                tests_failed++;
                $display("FAIL drop_phase n=%0d got=%b exp=%b", n, obs, phase_exp(n, 2, 1));
            end
            if (n == 9) bus.RUN = 1'b0;
            tick();
        end
        for (int n = 0; n < 4; n++) begin
            obs = {bus.PHI1, bus.nPHI1, bus.PHI2, bus.nPHI2, bus.BUSY};
            tests_run++;
            if (obs !== 5'b01010 || bus.STEP_DONE !== 1'b0 || bus.CYCLE_CNT !== 4'd2) begin
                tests_failed++;
                $display("FAIL drop_idle n=%0d got=%b done=%b cnt=%0d exp=01010 done=0 cnt=2", n, obs, bus.STEP_DONE, bus.CYCLE_CNT);
            end
            tick();
        end
    endtask

    task automatic test_zero_and_change();
        logic [4:0] obs;
        logic [4:0] exp;
        do_reset();
        bus.HIGH_CYC = 4'd0;
        bus.GAP_CYC = 4'd0;
        bus.RUN = 1'b1;
        tick();
        for (int n = 0; n < 12; n++) begin
            exp = (n < 4) ? phase_exp(n, 1, 1) : phase_exp(n - 4, 3, 1);
            obs = {bus.PHI1, bus.nPHI1, bus.PHI2, bus.nPHI2, bus.BUSY};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL zero_change n=%0d got=%b exp=%b", n, obs, exp);
            end
            if (n == 1) bus.HIGH_CYC = 4'd3;
            tick();
        end
        bus.RUN = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.HIGH_CYC = 4'd2;
        bus.GAP_CYC = 4'd1;
        bus.RUN = 1'b1;
        tick();
        for (int n = 0; n < 7; n++) tick();
        tests_run++;
        if (bus.PHI1 !== 1'b1 || bus.CYCLE_CNT !== 4'd1) begin
            tests_failed++;
            $display("FAIL arst_pre phi1=%b cnt=%0d exp=1 cnt=1", bus.PHI1, bus.CYCLE_CNT);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.PHI1 !== 1'b0 || bus.nPHI1 !== 1'b1 || bus.CYCLE_CNT !== 4'd0 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_immediate phi1=%b nphi1=%b cnt=%0d busy=%b exp=0 1 0 0", bus.PHI1, bus.nPHI1, bus.CYCLE_CNT, bus.BUSY);
        end
        tick();
        rst = 1'b0;
        tests_run++;
        if (bus.PHI1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_held_idle phi1=%b exp=0", bus.PHI1);
        end
        tick();
        tests_run++;
        if (bus.PHI1 !== 1'b1 || bus.nPHI1 !== 1'b0 || bus.CYCLE_CNT !== 4'd0) begin
            tests_failed++;
            $display("FAIL arst_restart phi1=%b nphi1=%b cnt=%0d exp=1 0 0", bus.PHI1, bus.nPHI1, bus.CYCLE_CNT);
        end
        bus.RUN = 1'b0;
    endtask

    task automatic test_wrap_and_step_ignored();
        bit idle_seen;
        do_reset();
        bus.HIGH_CYC = 4'd0;
        bus.GAP_CYC = 4'd0;
        bus.RUN = 1'b1;
        tick();
        for (int n = 0; n <= 64; n++) begin
            tests_run++;
            if (bus.CYCLE_CNT !== 4'((n / 4) % 16) || bus.STEP_DONE !== 1'b0) begin
                tests_failed++;
                $display("FAIL wrap n=%0d cnt=%0d done=%b exp cnt=%0d done=0", n, bus.CYCLE_CNT, bus.STEP_DONE, (n / 4) % 16);
            end
            bus.STEP = (n == 10);
            tick();
        end
        bus.STEP = 1'b0;
        bus.RUN = 1'b0;
        idle_seen = 1'b0;
        for (int n = 0; n < 10 && !idle_seen; n++) begin
            tick();
            if (bus.BUSY === 1'b0) idle_seen = 1'b1;
        end
        tests_run++;
        if (idle_seen !== 1'b1 || bus.STEP_DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_stop idle=%b done=%b exp=1 0", idle_seen, bus.STEP_DONE);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_run_h2g1();
        test_step();
        test_run_drop();
        test_zero_and_change();
        test_async_reset();
        test_wrap_and_step_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
